// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared widths, counter limit and FSM encoding for the hazard control unit.
package hazard_ctrl_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hcu_state_e;

    // Saturating increment: sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_reg_match.sv
// Register dependency check: a producer's rd against the IF/ID sources.
// Register 0 is hard-wired zero, so it never creates a dependency.
module reg_match
    import hazard_ctrl_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  uses_rt,
    output logic                  match
);

    // rt only counts when the consumer actually reads it.
    always_comb begin
        match = (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard detection: load-use and branch-operand stalls, taken-branch
// flush, plus saturating stall/flush event counters. Controls are Mealy.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  if_id_is_branch,
    input  logic                  branch_taken,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  hazardOutIFID,
    output logic                  pc_hold,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             match_idex, match_exmem;
    logic             haz_h1, haz_h2;
    logic             stall, flush;

    reg_match u_match_idex (
        .rd      (id_ex_rd),
        .rs      (if_id_rs),
        .rt      (if_id_rt),
        .uses_rt (if_id_uses_rt),
        .match   (match_idex)
    );

    reg_match u_match_exmem (
        .rd      (ex_mem_rd),
        .rs      (if_id_rs),
        .rt      (if_id_rt),
        .uses_rt (if_id_uses_rt),
        .match   (match_exmem)
    );

    // H2 (branch needs a load still in EX) costs two cycles; H1 costs one and
    // is re-evaluated each cycle. H2 is checked first so it wins over H1.
    always_comb begin
        haz_h2 = if_id_is_branch && id_ex_mem_read && match_idex;
        haz_h1 = (id_ex_mem_read && match_idex)
               || (if_id_is_branch && id_ex_reg_write && !id_ex_mem_read && match_idex)
               || (if_id_is_branch && ex_mem_mem_read && match_exmem);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state and Mealy stall/flush; reset forces controls low.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (haz_h2) begin
                    stall   = 1'b1;
                    state_d = HOLD;
                end else if (haz_h1) begin
                    stall = 1'b1;
                end else if (branch_taken) begin
                    flush = 1'b1;
                end
            end
            HOLD: begin
                stall   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    // Counter next-state: saturating increments on stall/flush cycles.
    always_comb begin
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // Event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hazardOutIFID = stall;
    assign pc_hold       = stall;
    assign id_ex_bubble  = stall;
    assign if_id_flush   = flush;
    assign stall_cycles  = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule
